ss_stack: RTL and testbench
===========================

SS_STACK -- requirements
Module: ss_stack

Interface
REQ-001 Parameter DEPTH, default 64: maximum element count including the cached tos/s0; power of 2, >=4.
REQ-002 Parameter DSZ, default 32: element width in bits.
REQ-003 Localparam SSZ = $clog2(DEPTH)+1: width of sp, which can represent 0..DEPTH.
REQ-004 clk  in  1: single clock; all state updates on posedge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 op  in  3: operation code. 0 NOP, 1 PUSH, 2 POP, 3 PICK, 4 LOAD, 5 DUP, 6 SWAP, 7 OVER.
REQ-007 valid  in  1: op and vi are qualified this cycle.
REQ-008 ready  out  1: block accepts an op this cycle; an op is accepted only when valid&ready.
REQ-009 vi  in  DSZ: push/load data.
REQ-010 err_clr  in  1: clears the sticky error flags.
REQ-011 tos  out  DSZ: cached top of stack (element sp-1).
REQ-012 s0  out  DSZ: cached next of stack (element sp-2).
REQ-013 sp  out  SSZ: element count.
REQ-014 full, empty  out  1 each: sp==DEPTH, sp==0 (combinational from sp).
REQ-015 ovf, udf  out  1 each: sticky overflow / underflow flags.

Function
REQ-016 Elements 0..sp-3 live in a DEPTH-2 entry synchronous-read RAM at index = element index; tos and s0 are registers.
REQ-017 PUSH/DUP/OVER push vi/tos/s0 respectively: mem[sp-2]<=s0 if sp>=2; s0<=tos; tos<=value; sp+1; completes in 1 cycle.
REQ-018 LOAD: tos<=vi, sp unchanged; SWAP: tos<=s0 and s0<=tos, requires sp>=2; both 1 cycle.
REQ-019 POP: tos<=s0, sp-1; if sp>=3, issue read of mem[sp-3] and enter FETCH; s0<=rdata on the next cycle; ready=0 during FETCH.
REQ-020 POP with sp==1 or sp==2 is 1 cycle; s0 is held unchanged (don't-care content).
REQ-021 PICK: u=tos (unsigned DSZ bits); u==0 -> tos<=s0 in 1 cycle; u>=1 -> read mem[sp-2-u], FETCH, tos<=rdata; sp unchanged.
REQ-022 The FSM has exactly two states: IDLE (ready=1) and FETCH (ready=0, one cycle, returns to IDLE).
REQ-023 Overflow: a push-class op with sp==DEPTH sets ovf; the stack is unchanged.
REQ-024 Underflow: POP with sp==0, DUP/LOAD with sp==0, SWAP/OVER with sp<2, or PICK with u>=sp-1 sets udf; the stack is unchanged and no FETCH is entered.
REQ-025 Errored ops complete in 1 cycle.
REQ-026 err_clr clears ovf/udf; if err_clr and a new error occur in the same cycle, the new error wins (flag=1).
REQ-027 Ops presented while ready=0 are ignored; the master holds valid until accepted.
REQ-028 NOP, or valid=0, leaves all state unchanged.
REQ-029 Outputs are registered.
REQ-030 tos/s0/sp reflect an accepted 1-cycle op on the next clock edge, and a FETCH op on the edge ending FETCH.

Reset
REQ-031 rst asserted, at any time including during FETCH: sp=0, tos=all ones, s0=0, ovf=udf=0, ready=1, FSM=IDLE, any pending read discarded.
REQ-032 RAM contents are not reset.

Verification
REQ-033 After reset: PUSH 1,2,3 -> sp=3, tos=3, s0=2; POP -> tos=2 next edge, ready=0 one cycle, then s0=1, sp=2.
REQ-034 Fill DEPTH=64 with PUSH 0..63 -> full=1; 65th PUSH -> ovf=1, tos=63, sp=64; err_clr -> ovf=0.
REQ-035 From empty: POP -> udf=1, sp=0, tos=all ones; SWAP with sp=1 -> udf=1.
REQ-036 Stack 10,20,30 then PUSH 2, PICK -> tos=10 after FETCH, sp=4; PICK with tos=5 -> udf=1, stack unchanged.
REQ-037 Stack 7,8: SWAP -> tos=7, s0=8; OVER -> tos=8, sp=3; DUP -> tos=8, sp=4.
REQ-038 Assert rst during POP FETCH -> sp=0, ready=1 immediately, no later s0 update.

Source files
------------

// File: rtl/ss_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ss_stack : data stack, tos/s0 cached in registers, rest in sync RAM |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ss_stack #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  localparam int SSZ  = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     i_op,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [DSZ-1:0] i_vi,
  input  logic           i_err_clr,
  output logic [DSZ-1:0] o_tos,
  output logic [DSZ-1:0] o_s0,
  output logic [SSZ-1:0] o_sp,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_ovf,
  output logic           o_udf
);
  localparam int AW = SSZ - 1;
  localparam int CW = ((DSZ > SSZ) ? DSZ : SSZ) + 1;
  localparam logic [2:0] c_OP_NOP  = 3'd0;
  localparam logic [2:0] c_OP_PUSH = 3'd1;
  localparam logic [2:0] c_OP_POP  = 3'd2;
  localparam logic [2:0] c_OP_PICK = 3'd3;
  localparam logic [2:0] c_OP_LOAD = 3'd4;
  localparam logic [2:0] c_OP_DUP  = 3'd5;
  localparam logic [2:0] c_OP_SWAP = 3'd6;
  localparam logic [2:0] c_OP_OVER = 3'd7;
  localparam logic [SSZ-1:0] c_SP_FULL = SSZ'(DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

  state_t         r_state;
  logic           r_ready;
  logic           r_fetch_tos;
  logic           r_ovf;
  logic           r_udf;
  logic [DSZ-1:0] r_tos;
  logic [DSZ-1:0] r_s0;
  logic [DSZ-1:0] r_rdata;
  logic [SSZ-1:0] r_sp;
  logic [DSZ-1:0] r_mem [0:DEPTH-3];

  logic           w_acc, w_push, w_bad, w_ok, w_pick_bad, w_u_zero;
  logic           w_sp_ge1, w_sp_ge2, w_sp_ge3;
  logic           w_ovf_ev, w_udf_ev, w_we, w_re;
  logic [AW-1:0]  w_waddr, w_raddr;
  logic [DSZ-1:0] w_push_val;

  always_comb begin
    w_acc      = i_valid && (r_state == S_IDLE);
    w_push     = (i_op == c_OP_PUSH) || (i_op == c_OP_DUP) || (i_op == c_OP_OVER);
    w_sp_ge1   = (r_sp != '0);
    w_sp_ge2   = (r_sp >= SSZ'(2));
    w_sp_ge3   = (r_sp >= SSZ'(3));
    w_u_zero   = (r_tos == '0);
    // u >= sp-1 rewritten as u+1 >= sp so sp==0 needs no special case
    w_pick_bad = (CW'(r_tos) + CW'(1)) >= CW'(r_sp);
    case (i_op)
      c_OP_POP, c_OP_DUP, c_OP_LOAD: w_bad = !w_sp_ge1;
      c_OP_SWAP, c_OP_OVER:          w_bad = !w_sp_ge2;
      c_OP_PICK:                     w_bad = w_pick_bad;
      default:                       w_bad = 1'b0;
    endcase
    w_ovf_ev = w_acc && w_push && (r_sp == c_SP_FULL);
    w_udf_ev = w_acc && !w_ovf_ev && w_bad;
    w_ok     = w_acc && !w_ovf_ev && !w_bad;
    case (i_op)
      c_OP_DUP:  w_push_val = r_tos;
      c_OP_OVER: w_push_val = r_s0;
      default:   w_push_val = i_vi;
    endcase
    w_we    = w_ok && w_push && w_sp_ge2;
    w_waddr = AW'(r_sp - SSZ'(2));
    w_re    = w_ok && (((i_op == c_OP_POP) && w_sp_ge3) || ((i_op == c_OP_PICK) && !w_u_zero));
    w_raddr = (i_op == c_OP_POP) ? AW'(r_sp - SSZ'(3))
                                 : AW'(r_sp - SSZ'(2) - SSZ'(r_tos));
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= r_s0;
    if (w_re) r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_fetch_tos <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_tos       <= '1;
      r_s0        <= '0;
      r_sp        <= '0;
    end else begin
      if (i_err_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_ovf_ev) r_ovf <= 1'b1;
      if (w_udf_ev) r_udf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_ok) begin
            case (i_op)
              c_OP_PUSH, c_OP_DUP, c_OP_OVER: begin
                r_s0  <= r_tos;
                r_tos <= w_push_val;
                r_sp  <= r_sp + SSZ'(1);
              end
              c_OP_POP: begin
                r_tos <= r_s0;
                r_sp  <= r_sp - SSZ'(1);
                if (w_sp_ge3) begin
                  r_state     <= S_FETCH;
                  r_ready     <= 1'b0;
                  r_fetch_tos <= 1'b0;
                end
              end
              c_OP_PICK: begin
                if (w_u_zero) begin
                  r_tos <= r_s0;
                end else begin
                  r_state     <= S_FETCH;
                  r_ready     <= 1'b0;
                  r_fetch_tos <= 1'b1;
                end
              end
              c_OP_LOAD: r_tos <= i_vi;
              c_OP_SWAP: begin
                r_tos <= r_s0;
                r_s0  <= r_tos;
              end
              c_OP_NOP: ;
              default: ;
            endcase
          end
        end
        S_FETCH: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          if (r_fetch_tos) r_tos <= r_rdata;
          else             r_s0  <= r_rdata;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_tos   = r_tos;
  assign o_s0    = r_s0;
  assign o_sp    = r_sp;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;
  assign o_full  = (r_sp == c_SP_FULL);
  assign o_empty = (r_sp == '0);
endmodule
`default_nettype wire

// File: tb/tb_ss_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ss_stack : queue-model bench for ss_stack, directed + random ops |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ss_stack;
  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int SSZ   = $clog2(DEPTH) + 1;
  localparam logic [2:0] c_NOP = 3'd0, c_PUSH = 3'd1, c_POP = 3'd2, c_PICK = 3'd3;
  localparam logic [2:0] c_LOAD = 3'd4, c_DUP = 3'd5, c_SWAP = 3'd6, c_OVER = 3'd7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2:0]     i_op = '0;
  logic           i_valid = 1'b0;
  logic [DSZ-1:0] i_vi = '0;
  logic           i_err_clr = 1'b0;
  logic           o_ready, o_full, o_empty, o_ovf, o_udf;
  logic [DSZ-1:0] o_tos, o_s0;
  logic [SSZ-1:0] o_sp;

  always #5 clk = ~clk;

  ss_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .i_op(i_op), .i_valid(i_valid), .o_ready(o_ready),
    .i_vi(i_vi), .i_err_clr(i_err_clr), .o_tos(o_tos), .o_s0(o_s0), .o_sp(o_sp),
    .o_full(o_full), .o_empty(o_empty), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DSZ-1:0] m_stk[$];
  bit m_ovf, m_udf, m_fetch, m_fetch_tos, m_fresh, m_en;
  int cmp_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected state lives in a plain queue; index k is stack element k.
  always @(negedge clk) begin
    if (m_en) begin
      cmp_n = m_stk.size();
      chk("sp", 64'(o_sp), 64'(cmp_n));
      chk("empty", 64'(o_empty), 64'(cmp_n == 0));
      chk("full", 64'(o_full), 64'(cmp_n == DEPTH));
      chk("ovf", 64'(o_ovf), 64'(m_ovf));
      chk("udf", 64'(o_udf), 64'(m_udf));
      chk("ready", 64'(o_ready), 64'(!m_fetch));
      if (cmp_n >= 1 && !(m_fetch && m_fetch_tos)) chk("tos", 64'(o_tos), 64'(m_stk[cmp_n-1]));
      if (cmp_n >= 2 && !(m_fetch && !m_fetch_tos)) chk("s0", 64'(o_s0), 64'(m_stk[cmp_n-2]));
      if (cmp_n == 0 && m_fresh) begin
        chk("rst_tos", 64'(o_tos), 64'({DSZ{1'b1}}));
        chk("rst_s0", 64'(o_s0), 64'(0));
      end
    end
  end

  task automatic model_reset();
    m_stk.delete();
    m_ovf = 0; m_udf = 0; m_fetch = 0; m_fetch_tos = 0; m_fresh = 1;
  endtask

  task automatic model_op(input logic [2:0] op, input logic [DSZ-1:0] v, input bit clr);
    int n, ui;
    bit ov, ud;
    logic [DSZ-1:0] u, t;
    n = m_stk.size(); ov = 0; ud = 0; m_fetch = 0;
    case (op)
      c_PUSH, c_DUP, c_OVER: begin
        if (n == DEPTH) ov = 1;
        else if (op == c_DUP && n < 1) ud = 1;
        else if (op == c_OVER && n < 2) ud = 1;
        else begin
          if (op == c_PUSH) t = v;
          else if (op == c_DUP) t = m_stk[n-1];
          else t = m_stk[n-2];
          m_stk.push_back(t);
          m_fresh = 0;
        end
      end
      c_POP: begin
        if (n == 0) ud = 1;
        else begin
          m_stk.delete(n-1);
          m_fresh = 0;
          if (n >= 3) begin m_fetch = 1; m_fetch_tos = 0; end
        end
      end
      c_PICK: begin
        if (n == 0) ud = 1;
        else begin
          u = m_stk[n-1];
          if (64'(u) >= 64'(n-1)) ud = 1;
          else begin
            ui = int'(u);
            m_stk[n-1] = m_stk[n-2-ui];
            m_fresh = 0;
            if (ui != 0) begin m_fetch = 1; m_fetch_tos = 1; end
          end
        end
      end
      c_LOAD: begin
        if (n == 0) ud = 1;
        else begin m_stk[n-1] = v; m_fresh = 0; end
      end
      c_SWAP: begin
        if (n < 2) ud = 1;
        else begin
          t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; m_fresh = 0;
        end
      end
      default: ;
    endcase
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (ov) m_ovf = 1;
    if (ud) m_udf = 1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [DSZ-1:0] v, input bit clr);
    i_op = op; i_vi = v; i_valid = 1'b1; i_err_clr = clr;
    @(posedge clk); #1;
    model_op(op, v, clr);
    i_valid = 1'b0; i_err_clr = 1'b0;
  endtask

  // A junk PUSH is held during the busy cycle; it must be ignored.
  task automatic finish_fetch();
    if (m_fetch) begin
      i_valid = 1'b1; i_op = c_PUSH; i_vi = $urandom;
      @(posedge clk); #1;
      i_valid = 1'b0;
      m_fetch = 0;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [DSZ-1:0] v, input bit clr);
    issue(op, v, clr);
    finish_fetch();
  endtask

  task automatic idle(input bit clr);
    i_valid = 1'b0; i_op = 3'($urandom_range(0, 7)); i_vi = $urandom; i_err_clr = clr;
    @(posedge clk); #1;
    i_err_clr = 1'b0;
    if (clr) begin m_ovf = 0; m_udf = 0; end
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [2:0]     g_op;
  logic [DSZ-1:0] g_v;
  int             g_r;

  initial begin
    m_en = 0;
    model_reset();
    do_reset();
    m_en = 1;
    chk("reset_sp", 64'(o_sp), 64'(0));
    chk("reset_tos", 64'(o_tos), 64'(32'hFFFF_FFFF));
    chk("reset_s0", 64'(o_s0), 64'(0));
    chk("reset_ready", 64'(o_ready), 64'(1));
    chk("reset_empty", 64'(o_empty), 64'(1));

    // push three, then pop with refill from RAM
    do_op(c_PUSH, 1, 0); do_op(c_PUSH, 2, 0); do_op(c_PUSH, 3, 0);
    chk("p3_sp", 64'(o_sp), 64'(3));
    chk("p3_tos", 64'(o_tos), 64'(3));
    chk("p3_s0", 64'(o_s0), 64'(2));
    issue(c_POP, 0, 0);
    chk("pop_tos", 64'(o_tos), 64'(2));
    chk("pop_busy", 64'(o_ready), 64'(0));
    finish_fetch();
    chk("pop_s0", 64'(o_s0), 64'(1));
    chk("pop_sp", 64'(o_sp), 64'(2));
    chk("pop_ready", 64'(o_ready), 64'(1));

    // fill to full and overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(c_PUSH, DSZ'(i), 0);
    chk("fill_full", 64'(o_full), 64'(1));
    do_op(c_PUSH, 99, 0);
    chk("ovf_flag", 64'(o_ovf), 64'(1));
    chk("ovf_tos", 64'(o_tos), 64'(63));
    chk("ovf_sp", 64'(o_sp), 64'(64));
    do_op(c_NOP, 0, 1);
    chk("ovf_clr", 64'(o_ovf), 64'(0));

    // underflows from empty / single element
    do_reset();
    do_op(c_POP, 0, 0);
    chk("udf_pop", 64'(o_udf), 64'(1));
    chk("udf_sp", 64'(o_sp), 64'(0));
    chk("udf_tos", 64'(o_tos), 64'(32'hFFFF_FFFF));
    do_op(c_NOP, 0, 1);
    do_op(c_PUSH, 5, 0);
    do_op(c_SWAP, 0, 0);
    chk("udf_swap", 64'(o_udf), 64'(1));
    chk("udf_swap_tos", 64'(o_tos), 64'(5));

    // PICK from RAM, then out-of-range PICK
    do_reset();
    do_op(c_PUSH, 10, 0); do_op(c_PUSH, 20, 0); do_op(c_PUSH, 30, 0); do_op(c_PUSH, 2, 0);
    issue(c_PICK, 0, 0);
    chk("pick_busy", 64'(o_ready), 64'(0));
    finish_fetch();
    chk("pick_tos", 64'(o_tos), 64'(10));
    chk("pick_sp", 64'(o_sp), 64'(4));
    chk("pick_s0", 64'(o_s0), 64'(30));
    do_op(c_LOAD, 5, 0);
    do_op(c_PICK, 0, 0);
    chk("pick_udf", 64'(o_udf), 64'(1));
    chk("pick_udf_sp", 64'(o_sp), 64'(4));
    chk("pick_udf_tos", 64'(o_tos), 64'(5));

    // SWAP / OVER / DUP
    do_reset();
    do_op(c_PUSH, 7, 0); do_op(c_PUSH, 8, 0);
    do_op(c_SWAP, 0, 0);
    chk("swap_tos", 64'(o_tos), 64'(7));
    chk("swap_s0", 64'(o_s0), 64'(8));
    do_op(c_OVER, 0, 0);
    chk("over_tos", 64'(o_tos), 64'(8));
    chk("over_sp", 64'(o_sp), 64'(3));
    do_op(c_DUP, 0, 0);
    chk("dup_tos", 64'(o_tos), 64'(8));
    chk("dup_sp", 64'(o_sp), 64'(4));

    // reset in the middle of a POP refill
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(c_PUSH, DSZ'(i), 0);
    issue(c_POP, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_sp", 64'(o_sp), 64'(0));
    chk("midrst_ready", 64'(o_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) idle(0);
    chk("midrst_s0", 64'(o_s0), 64'(0));
    chk("midrst_tos", 64'(o_tos), 64'(32'hFFFF_FFFF));

    // random traffic: alternating fill-biased and drain-biased phases
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      g_r = $urandom_range(0, 19);
      if (((k / 250) % 2) == 0)
        g_op = g_r < 10 ? c_PUSH : g_r < 12 ? c_DUP : g_r < 14 ? c_OVER : g_r < 15 ? c_POP :
               g_r < 17 ? c_PICK : g_r < 18 ? c_LOAD : g_r < 19 ? c_SWAP : c_NOP;
      else
        g_op = g_r < 3 ? c_PUSH : g_r < 4 ? c_DUP : g_r < 5 ? c_OVER : g_r < 12 ? c_POP :
               g_r < 15 ? c_PICK : g_r < 17 ? c_LOAD : g_r < 19 ? c_SWAP : c_NOP;
      g_v = ($urandom_range(0, 1) == 1) ? DSZ'($urandom) : DSZ'($urandom_range(0, 6));
      if (g_op == c_PICK && $urandom_range(0, 1) == 1)
        do_op(c_LOAD, DSZ'($urandom_range(0, 6)), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 7) == 0);
      do_op(g_op, g_v, $urandom_range(0, 15) == 0);
    end

    m_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
